// File: rtl/osc_ctrl_pkg.sv
// Shared types and helpers for the oscillator request controller.
//   osc_state_e : controller state encoding
//   cnt_width   : bits needed to hold a counter value up to max_val
//   Def*        : default parameter values
package osc_ctrl_pkg;

    typedef enum logic [2:0] {
        StOff   = 3'd0,
        StStart = 3'd1,
        StRun   = 3'd2,
        StHold  = 3'd3,
        StFault = 3'd4
    } osc_state_e;

    localparam int unsigned DefNReq           = 4;
    localparam int unsigned DefStartupCycles  = 64;
    localparam int unsigned DefMinEdges       = 8;
    localparam int unsigned DefTimeoutCycles  = 1024;
    localparam int unsigned DefHoldoffCycles  = 256;
    localparam int unsigned DefWatchdogCycles = 128;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector for an asynchronous strobe.
//   clk      : destination clock
//   rst_n    : asynchronous active-low reset
//   async_in : asynchronous input
//   edge_p   : one-cycle pulse per rising edge of async_in (decoded from flops only)
module osc_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_p
);

    // [0],[1] form the synchronizer; [2] holds the previous synchronized value.
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], async_in};
        end
    end

    assign edge_p = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/osc_req_ctrl.sv
// Shares the on-chip oscillator between N_REQ requesters on the system clock.
//   clk, rst_n : system clock, asynchronous active-low reset
//   req        : per-requester level request
//   ack        : per-requester grant, high only while running and requested
//   oscen      : oscillator enable
//   oscout     : oscillator output, asynchronous to clk
//   osc_ready  : high while the oscillator is qualified and granted (RUN)
//   fault      : sticky start/liveness fault
//   fault_clr  : pulse that clears the fault
module osc_req_ctrl
    import osc_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ           = DefNReq,
    parameter int unsigned STARTUP_CYCLES  = DefStartupCycles,
    parameter int unsigned MIN_EDGES       = DefMinEdges,
    parameter int unsigned TIMEOUT_CYCLES  = DefTimeoutCycles,
    parameter int unsigned HOLDOFF_CYCLES  = DefHoldoffCycles,
    parameter int unsigned WATCHDOG_CYCLES = DefWatchdogCycles
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] ack,
    output logic             oscen,
    input  logic             oscout,
    output logic             osc_ready,
    output logic             fault,
    input  logic             fault_clr
);

    localparam int unsigned CycW  = cnt_width(max_u(STARTUP_CYCLES, TIMEOUT_CYCLES));
    localparam int unsigned EdgeW = cnt_width(MIN_EDGES);
    localparam int unsigned HoldW = cnt_width(HOLDOFF_CYCLES);
    localparam int unsigned WdW   = cnt_width(WATCHDOG_CYCLES);

    localparam logic [CycW-1:0]  StartupLast = CycW'(STARTUP_CYCLES - 1);
    localparam logic [CycW-1:0]  TimeoutLast = CycW'(TIMEOUT_CYCLES - 1);
    localparam logic [EdgeW-1:0] EdgeMax     = EdgeW'(MIN_EDGES);
    localparam logic [HoldW-1:0] HoldLast    = HoldW'(HOLDOFF_CYCLES - 1);
    localparam logic [WdW-1:0]   WdLast      = WdW'(WATCHDOG_CYCLES - 1);

    osc_state_e       state_q, state_d;
    logic [CycW-1:0]  cyc_q, cyc_d;
    logic [EdgeW-1:0] edge_q, edge_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [WdW-1:0]   wd_q, wd_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             edge_p;
    logic             any_req;
    logic             wd_active;
    logic             wd_expired;

    osc_edge_sync u_edge_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (oscout),
        .edge_p   (edge_p)
    );

    assign any_req    = |req;
    assign wd_active  = (state_q == StRun) || (state_q == StHold);
    assign wd_expired = wd_active && (wd_q == WdLast);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        edge_d  = edge_q;
        hold_d  = hold_q;
        wd_d    = '0;

        if (wd_active) begin
            if (edge_p) begin
                wd_d = '0;
            end else if (wd_q != WdLast) begin
                wd_d = wd_q + WdW'(1);
            end else begin
                wd_d = wd_q;
            end
        end

        case (state_q)
            StOff: begin
                if (any_req) begin
                    state_d = StStart;
                    cyc_d   = '0;
                    edge_d  = '0;
                end
            end
            StStart: begin
                if (cyc_q != '1) cyc_d = cyc_q + CycW'(1);
                if (edge_p && (edge_q != EdgeMax)) edge_d = edge_q + EdgeW'(1);
                // Requests dropping here are ignored; RUN immediately falls through to HOLD.
                if ((cyc_q >= StartupLast) && (edge_q == EdgeMax)) begin
                    state_d = StRun;
                end else if (cyc_q == TimeoutLast) begin
                    state_d = StFault;
                end
            end
            StRun: begin
                if (wd_expired) begin
                    state_d = StFault;
                end else if (!any_req) begin
                    state_d = StHold;
                    hold_d  = '0;
                end
            end
            StHold: begin
                if (hold_q != HoldLast) hold_d = hold_q + HoldW'(1);
                // A request on the expiry cycle keeps the oscillator on.
                if (wd_expired) begin
                    state_d = StFault;
                end else if (any_req) begin
                    state_d = StRun;
                end else if (hold_q == HoldLast) begin
                    state_d = StOff;
                end
            end
            StFault: begin
                if (fault_clr) state_d = StOff;
            end
            default: state_d = StOff;
        endcase

        // Grants only persist while staying in RUN, so they drop on the FAULT entry cycle.
        ack_d = ((state_q == StRun) && (state_d == StRun)) ? req : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StOff;
            cyc_q   <= '0;
            edge_q  <= '0;
            hold_q  <= '0;
            wd_q    <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            edge_q  <= edge_d;
            hold_q  <= hold_d;
            wd_q    <= wd_d;
            ack_q   <= ack_d;
        end
    end

    // Decoded straight from the state register so reset drops oscen without a clock.
    assign oscen     = (state_q == StStart) || (state_q == StRun) || (state_q == StHold);
    assign osc_ready = (state_q == StRun);
    assign fault     = (state_q == StFault);
    assign ack       = ack_q;

endmodule

// File: tb/tb_osc_req_ctrl.sv
module tb_osc_req_ctrl;

    localparam int NR      = 4;
    localparam int STARTUP = 64;
    localparam int MINE    = 8;
    localparam int TMO     = 1024;
    localparam int HOLDC   = 256;
    localparam int WD      = 128;

    localparam int M_OFF   = 0;
    localparam int M_START = 1;
    localparam int M_RUN   = 2;
    localparam int M_HOLD  = 3;
    localparam int M_FAULT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req = '0;
    logic          fault_clr = 1'b0;
    logic          oscout = 1'b0;
    logic [NR-1:0] ack;
    logic          oscen;
    logic          osc_ready;
    logic          fault;

    osc_req_ctrl #(
        .N_REQ           (NR),
        .STARTUP_CYCLES  (STARTUP),
        .MIN_EDGES       (MINE),
        .TIMEOUT_CYCLES  (TMO),
        .HOLDOFF_CYCLES  (HOLDC),
        .WATCHDOG_CYCLES (WD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ack       (ack),
        .oscen     (oscen),
        .oscout    (oscout),
        .osc_ready (osc_ready),
        .fault     (fault),
        .fault_clr (fault_clr)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: spec rules over plain integers and a sample history of oscout.
    int            m_st;
    int            m_cyc, m_edges, m_hold, m_wd;
    logic [NR-1:0] m_ack;
    logic          x1, x2, x3;

    bit osc_alive;
    int osc_half;
    int osc_ph;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_OFF;
        m_cyc = 0; m_edges = 0; m_hold = 0; m_wd = 0;
        m_ack = '0;
        x1 = 1'b0; x2 = 1'b0; x3 = 1'b0;
    endtask

    function automatic bit m_on();
        return (m_st == M_START) || (m_st == M_RUN) || (m_st == M_HOLD);
    endfunction

    // One clock edge of the reference model; edge seen 3 samples after the oscout rise.
    task automatic model_step();
        bit e;
        int nst;
        e   = x2 & ~x3;
        x3  = x2; x2 = x1; x1 = oscout;
        nst = m_st;
        case (m_st)
            M_OFF: if (req != 0) begin nst = M_START; m_cyc = 0; m_edges = 0; end
            M_START: begin
                if (m_cyc >= STARTUP - 1 && m_edges == MINE) nst = M_RUN;
                else if (m_cyc == TMO - 1) nst = M_FAULT;
                m_cyc = m_cyc + 1;
                if (e && m_edges < MINE) m_edges = m_edges + 1;
            end
            M_RUN: begin
                if (m_wd == WD - 1) nst = M_FAULT;
                else if (req == 0) begin nst = M_HOLD; m_hold = 0; end
            end
            M_HOLD: begin
                if (m_wd == WD - 1) nst = M_FAULT;
                else if (req != 0) nst = M_RUN;
                else if (m_hold == HOLDC - 1) nst = M_OFF;
                if (m_hold < HOLDC - 1) m_hold = m_hold + 1;
            end
            M_FAULT: if (fault_clr) nst = M_OFF;
            default: nst = M_OFF;
        endcase
        if (m_st == M_RUN || m_st == M_HOLD) m_wd = e ? 0 : ((m_wd < WD - 1) ? m_wd + 1 : m_wd);
        else m_wd = 0;
        m_ack = (m_st == M_RUN && nst == M_RUN) ? req : '0;
        m_st  = nst;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
        check("oscen", oscen, m_on());
        check("osc_ready", osc_ready, m_st == M_RUN);
        check("fault", fault, m_st == M_FAULT);
        check("ack", ack, m_ack);
        if (osc_alive && m_on()) begin
            osc_ph++;
            if (osc_ph >= osc_half) begin
                oscout = ~oscout;
                osc_ph = 0;
            end
        end
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n;
        n = 0;
        while (!osc_ready && n < budget) begin
            tick();
            n++;
        end
        check(tag, osc_ready, 1'b1);
    endtask

    initial begin
        int n;
        model_reset();
        osc_alive = 1'b0;
        osc_half  = 5;
        osc_ph    = 0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_oscen", oscen, 1'b0);
        check("rst_ack", ack, 4'b0000);
        check("rst_ready", osc_ready, 1'b0);
        check("rst_fault", fault, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Cold start, oscout at 1/10 clk rate
        osc_alive = 1'b1;
        req = 4'b0001;
        tick();
        check("cold_oscen", oscen, 1'b1);
        n = 1;
        while (!osc_ready && n < 300) begin
            tick();
            n++;
        end
        check("cold_run", osc_ready, 1'b1);
        check("cold_min_startup", n > STARTUP, 1'b1);
        check("cold_ack_entry", ack, 4'b0000);
        tick();
        check("cold_ack0", ack, 4'b0001);

        // Hold-off and re-grab
        req = 4'b0000;
        tick();
        check("drop_ack", ack, 4'b0000);
        check("drop_hold", {oscen, osc_ready}, 2'b10);
        for (int k = 0; k < 300 && m_hold < 100; k++) tick();
        req = 4'b0100;
        tick();
        check("regrab_run", osc_ready, 1'b1);
        check("regrab_ack_lat", ack, 4'b0000);
        tick();
        check("regrab_ack2", ack, 4'b0100);
        req = 4'b0000;
        tick();
        repeat (HOLDC - 1) tick();
        check("hold_last_on", oscen, 1'b1);
        tick();
        check("hold_expired_off", oscen, 1'b0);

        // Expiry collision
        req = 4'b0001;
        wait_ready("coll_run0", 300);
        req = 4'b0000;
        tick();
        repeat (HOLDC - 1) tick();
        req = 4'b0010;
        tick();
        check("coll_oscen", oscen, 1'b1);
        check("coll_run", osc_ready, 1'b1);
        tick();
        check("coll_ack1", ack, 4'b0010);

        // Watchdog: oscout stops in RUN
        osc_alive = 1'b0;
        n = 0;
        while (!fault && n < WD + 20) begin
            tick();
            n++;
        end
        check("wd_fault", fault, 1'b1);
        check("wd_bound", n <= WD + 3, 1'b1);
        check("wd_ack", ack, 4'b0000);
        check("wd_oscen", oscen, 1'b0);

        // Clear with request held: OFF then START
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("clr_off", {fault, oscen}, 2'b00);
        req = 4'b1000;
        tick();
        check("clr_restart", oscen, 1'b1);

        // Start timeout with oscout dead; clear pulse on the entry cycle is ignored
        repeat (TMO - 1) tick();
        check("tmo_pre", {fault, oscen}, 2'b01);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("tmo_fault", fault, 1'b1);
        check("tmo_oscen", oscen, 1'b0);
        check("tmo_ack", ack, 4'b0000);
        tick();
        check("tmo_clr_ignored", fault, 1'b1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("tmo_clr_off", {fault, oscen}, 2'b00);
        tick();
        check("tmo_retry", oscen, 1'b1);

        // Asynchronous reset mid-RUN
        osc_alive = 1'b1;
        req = 4'b0101;
        wait_ready("arst_run", 300);
        tick();
        check("arst_ack_pre", ack, 4'b0101);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_oscen", oscen, 1'b0);
        check("arst_ack", ack, 4'b0000);
        check("arst_ready", osc_ready, 1'b0);
        model_reset();
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        check("arst_restart", oscen, 1'b1);

        // Randomized traffic against the model
        repeat (4000) begin
            if ($urandom_range(0, 15) == 0) req = NR'($urandom_range(0, 15));
            fault_clr = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 299) == 0) osc_alive = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) osc_half = $urandom_range(2, 8);
            tick();
        end
        fault_clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
